// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// FETCH_PREDECODE_EN adds predecode flags to every buffered entry.
package fetch_pkg;

    localparam int          INSTR_W      = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int          DROP_W       = 8;

    localparam int          OP_HI     = 27;
    localparam int          OP_LO     = 26;
    localparam int          BR_HI     = 27;
    localparam int          BR_LO     = 25;
    localparam logic [1:0]  OP_MEM    = 2'b01;
    localparam logic [2:0]  OP_BRANCH = 3'b101;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc;
`ifdef FETCH_PREDECODE_EN
        logic               is_branch;
        logic               is_mem;
`endif
    } fetch_entry_t;

    function automatic fetch_entry_t make_entry(input logic [INSTR_W-1:0] instr,
                                                input logic [31:0]        pc);
        fetch_entry_t e;
        e.instr = instr;
        e.pc    = pc;
`ifdef FETCH_PREDECODE_EN
        e.is_branch = (instr[BR_HI:BR_LO] == OP_BRANCH);
        e.is_mem    = (instr[OP_HI:OP_LO] == OP_MEM);
`endif
        return e;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Purpose: small FIFO of fetch entries with synchronous flush; head reads as zero when empty.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: caller never pushes when full; a pop on an empty FIFO is ignored.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  fetch_entry_t  push_dat,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  head_dat,
    output logic [CW-1:0] count,
    output logic          empty
);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_pop;

    assign empty  = (count_q == '0);
    assign do_pop = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_dat = empty ? '0 : mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Purpose: in-order instruction fetch into a DEPTH-entry buffer, redirected by branch_taken (FETCH_PREDECODE_EN adds is_branch/is_mem).
// Latency: an instruction is presented the cycle after its memory response; outputs are combinational from the buffer head.
// Backpressure: issue stops once buffered plus in-flight words reach DEPTH; the head holds while instr_ready is low.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter  logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter  int          DEPTH    = 2,
    localparam int          AW       = $clog2(DEPTH),
    localparam int          CW       = AW + 1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc
`ifdef FETCH_PREDECODE_EN
    ,
    output logic        is_branch,
    output logic        is_mem
`endif
);

    localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

    logic [31:0]       pc_q, pc_d;
    logic [CW-1:0]     inflight_q, inflight_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic [31:0]       aq_q [DEPTH];
    logic [31:0]       aq_d [DEPTH];
    logic [AW-1:0]     aq_rd_q, aq_rd_d;
    logic [AW-1:0]     aq_wr_q, aq_wr_d;

    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;
    fetch_entry_t      head;
    logic [CW:0]       occupancy;
    logic              issue;
    logic              keep;

    assign occupancy = {1'b0, fifo_count} + {1'b0, inflight_q};
    assign issue     = rst && !branch_taken && (occupancy < DEPTH_L);
    // Responses owed to requests cancelled by a redirect arrive first and are swallowed.
    assign keep      = imem_rvalid && (drop_q == '0) && !branch_taken;

    always_comb begin
        pc_d       = pc_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        aq_d       = aq_q;
        aq_rd_d    = aq_rd_q;
        aq_wr_d    = aq_wr_q;
        if (branch_taken) begin
            pc_d       = branch_target & ~32'h3;
            inflight_d = '0;
            drop_d     = drop_q + DROP_W'(inflight_q) - DROP_W'(imem_rvalid);
            aq_rd_d    = '0;
            aq_wr_d    = '0;
        end else begin
            if (issue) begin
                pc_d          = pc_q + 32'd4;
                aq_d[aq_wr_q] = pc_q;
                aq_wr_d       = aq_wr_q + 1'b1;
            end
            if (imem_rvalid && (drop_q != '0)) begin
                drop_d = drop_q - 1'b1;
            end
            if (keep) begin
                aq_rd_d = aq_rd_q + 1'b1;
            end
            inflight_d = inflight_q + CW'(issue) - CW'(keep);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                aq_q[i] <= '0;
            end
            aq_rd_q    <= '0;
            aq_wr_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            aq_q       <= aq_d;
            aq_rd_q    <= aq_rd_d;
            aq_wr_q    <= aq_wr_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (keep),
        .push_dat (make_entry(imem_rdata, aq_q[aq_rd_q])),
        .pop      (instr_valid && instr_ready),
        .flush    (branch_taken),
        .head_dat (head),
        .count    (fifo_count),
        .empty    (fifo_empty)
    );

    assign imem_req    = issue;
    assign imem_addr   = pc_q;
    assign instr_valid = !fifo_empty;
    assign instr_out   = head.instr;
    assign instr_pc    = head.pc;
`ifdef FETCH_PREDECODE_EN
    assign is_branch   = head.is_branch;
    assign is_mem      = head.is_mem;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus randomized traffic against an in-order memory and a queue-based model.
module tb_instr_fetch;
    import fetch_pkg::*;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] W_PC   = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_rvalid, branch_taken, instr_valid, instr_ready;
    logic [31:0] imem_addr, imem_rdata, branch_target, instr_out, instr_pc;
    logic        w_req, w_valid;
    logic [31:0] w_addr, w_out, w_pc;
    logic        w_rvalid = 1'b0, w_branch = 1'b0, w_ready = 1'b0;
    logic [31:0] w_rdata = 32'h0, w_target = 32'h0;
`ifdef FETCH_PREDECODE_EN
    logic        is_branch, is_mem, w_isb, w_ism;
`endif

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_out(instr_out), .instr_pc(instr_pc)
`ifdef FETCH_PREDECODE_EN
        , .is_branch(is_branch), .is_mem(is_mem)
`endif
    );

    instr_fetch #(.RESET_PC(W_PC), .DEPTH(DEPTH)) u_wrap (
        .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr),
        .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .branch_taken(w_branch), .branch_target(w_target),
        .instr_valid(w_valid), .instr_ready(w_ready),
        .instr_out(w_out), .instr_pc(w_pc)
`ifdef FETCH_PREDECODE_EN
        , .is_branch(w_isb), .is_mem(w_ism)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } req_t;

    req_t        memq[$];
    logic [31:0] buf_pc[$];
    logic [31:0] iss_q[$];
    logic [31:0] acc_pc[$];
    logic [31:0] acc_in[$];
    logic [31:0] exp_issue;
    int          tests_run    = 0;
    int          tests_failed = 0;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        case (a)
            32'h0:   return 32'hE086_5007;
            32'h4:   return 32'hE405_B01A;
            32'h8:   return 32'hBA00_0003;
            default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
        endcase
    endfunction

    // One clock cycle: memory answers, inputs are driven, outputs are checked against the model.
    task automatic step(input bit br, input logic [31:0] tgt, input bit rdy, input int rv_pct);
        req_t        rsp;
        bit          has_rsp;
        bit          exp_req;
        int          live;
        logic [31:0] exp_pc, exp_in;
        @(negedge clk);
        has_rsp = 1'b0;
        if (memq.size() > 0 && int'($urandom_range(99)) < rv_pct) begin
            rsp     = memq.pop_front();
            has_rsp = 1'b1;
        end
        imem_rvalid   = has_rsp;
        imem_rdata    = has_rsp ? memfn(rsp.addr) : $urandom;
        branch_taken  = br;
        branch_target = tgt;
        instr_ready   = rdy;
        #1;
        tests_run++;
        if (buf_pc.size() > 0) begin
            exp_pc = buf_pc[0];
            exp_in = memfn(exp_pc);
            if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr_out !== exp_in) begin
                tests_failed++;
                $display("FAIL head t=%0t got v=%b pc=%h in=%h want v=1 pc=%h in=%h",
                         $time, instr_valid, instr_pc, instr_out, exp_pc, exp_in);
            end
        end else begin
            exp_in = 32'h0;
            if (instr_valid !== 1'b0 || instr_pc !== 32'h0 || instr_out !== 32'h0) begin
                tests_failed++;
                $display("FAIL empty_head t=%0t got v=%b pc=%h in=%h want all zero",
                         $time, instr_valid, instr_pc, instr_out);
            end
        end
`ifdef FETCH_PREDECODE_EN
        tests_run++;
        if (is_branch !== (exp_in[27:25] == 3'b101) || is_mem !== (exp_in[27:26] == 2'b01)) begin
            tests_failed++;
            $display("FAIL predecode t=%0t got br=%b mem=%b for instr %h", $time, is_branch, is_mem, exp_in);
        end
`endif
        live = buf_pc.size() + ((has_rsp && !rsp.stale) ? 1 : 0);
        foreach (memq[i]) if (!memq[i].stale) live++;
        exp_req = !br && (live < DEPTH);
        tests_run++;
        if (imem_req !== exp_req) begin
            tests_failed++;
            $display("FAIL imem_req t=%0t got %b want %b", $time, imem_req, exp_req);
        end
        if (imem_req === 1'b1) begin
            tests_run++;
            if (imem_addr !== exp_issue) begin
                tests_failed++;
                $display("FAIL imem_addr t=%0t got %h want %h", $time, imem_addr, exp_issue);
            end
        end
        if (buf_pc.size() > 0 && rdy) begin
            acc_pc.push_back(buf_pc[0]);
            acc_in.push_back(instr_out);
            void'(buf_pc.pop_front());
        end
        if (br) begin
            buf_pc.delete();
            foreach (memq[i]) memq[i].stale = 1'b1;
            exp_issue = tgt & ~32'h3;
        end else if (has_rsp && !rsp.stale) begin
            buf_pc.push_back(rsp.addr);
        end
        if (imem_req === 1'b1) begin
            memq.push_back('{imem_addr, 1'b0});
            iss_q.push_back(imem_addr);
        end
        if (exp_req) exp_issue = exp_issue + 32'd4;
    endtask

    // Asserts reset at a falling edge, checks outputs at once, releases just after a rising edge.
    task automatic apply_reset();
        @(negedge clk);
        rst          = 1'b0;
        imem_rvalid  = 1'b0;
        branch_taken = 1'b0;
        instr_ready  = 1'b0;
        #1;
        tests_run++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr_out !== 32'h0 || instr_pc !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs got req=%b v=%b in=%h pc=%h want all zero",
                     imem_req, instr_valid, instr_out, instr_pc);
        end
        memq.delete();
        buf_pc.delete();
        iss_q.delete();
        acc_pc.delete();
        acc_in.delete();
        exp_issue = RST_PC;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] want [3];
        want[0] = 32'hFFFF_FFFC;
        want[1] = 32'h0000_0000;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 1'b0, 0);
            tests_run++;
            if (i < 2 && (w_req !== 1'b1 || w_addr !== want[i])) begin
                tests_failed++;
                $display("FAIL wrap_req%0d got req=%b addr=%h want req=1 addr=%h", i, w_req, w_addr, want[i]);
            end else if (i == 2 && w_req !== 1'b0) begin
                tests_failed++;
                $display("FAIL wrap_stop got req=%b want 0", w_req);
            end
        end
    endtask

    task automatic test_sequential();
        logic [31:0] words [3];
        words[0] = 32'hE086_5007;
        words[1] = 32'hE405_B01A;
        words[2] = 32'hBA00_0003;
        apply_reset();
        repeat (12) step(1'b0, 32'h0, 1'b1, 100);
        tests_run++;
        if (iss_q.size() < 3 || acc_pc.size() < 3) begin
            tests_failed++;
            $display("FAIL seq_count got issued=%0d accepted=%0d want >=3 each", iss_q.size(), acc_pc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests_run++;
                if (iss_q[i] !== 32'(4 * i) || acc_pc[i] !== 32'(4 * i) || acc_in[i] !== words[i]) begin
                    tests_failed++;
                    $display("FAIL seq%0d got req=%h pc=%h in=%h want addr %h instr %h",
                             i, iss_q[i], acc_pc[i], acc_in[i], 32'(4 * i), words[i]);
                end
            end
        end
    endtask

    task automatic test_stall();
        bit seen;
        apply_reset();
        repeat (6) step(1'b0, 32'h0, 1'b0, 100);
        tests_run++;
        if (iss_q.size() != 2 || iss_q[0] !== 32'h0 || iss_q[1] !== 32'h4) begin
            tests_failed++;
            $display("FAIL stall_issue got %0d requests want exactly 0x0,0x4", iss_q.size());
        end
        tests_run++;
        if (instr_valid !== 1'b1 || instr_out !== 32'hE086_5007 || instr_pc !== 32'h0) begin
            tests_failed++;
            $display("FAIL stall_head got v=%b in=%h pc=%h want 1 E0865007 0", instr_valid, instr_out, instr_pc);
        end
        iss_q.delete();
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(1'b0, 32'h0, 1'b1, 100);
            seen = (iss_q.size() > 0);
        end
        tests_run++;
        if (!seen || iss_q[0] !== 32'h8) begin
            tests_failed++;
            $display("FAIL stall_resume got seen=%b addr=%h want 00000008", seen, seen ? iss_q[0] : 32'h0);
        end
    endtask

    task automatic test_flush();
        apply_reset();
        repeat (2) step(1'b0, 32'h0, 1'b0, 0);
        tests_run++;
        if (iss_q.size() != 2) begin
            tests_failed++;
            $display("FAIL flush_setup got %0d in flight want 2", iss_q.size());
        end
        iss_q.delete();
        step(1'b1, 32'h22, 1'b0, 0);
        repeat (10) step(1'b0, 32'h0, 1'b1, 100);
        tests_run++;
        if (iss_q.size() == 0 || acc_pc.size() == 0 || iss_q[0] !== 32'h20 || acc_pc[0] !== 32'h20
            || acc_in[0] !== memfn(32'h20)) begin
            tests_failed++;
            $display("FAIL flush_target got issued=%0d accepted=%0d want first req/pc 00000020",
                     iss_q.size(), acc_pc.size());
        end
    endtask

    task automatic test_rsp_branch();
        apply_reset();
        step(1'b0, 32'h0, 1'b1, 100);
        step(1'b1, 32'h40, 1'b1, 100);
        step(1'b0, 32'h0, 1'b1, 0);
        tests_run++;
        if (instr_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rsp_branch_empty got v=%b want 0", instr_valid);
        end
        repeat (6) step(1'b0, 32'h0, 1'b1, 100);
        tests_run++;
        if (acc_pc.size() == 0 || acc_pc[0] !== 32'h40) begin
            tests_failed++;
            $display("FAIL rsp_branch_next got n=%0d want first pc 00000040", acc_pc.size());
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        repeat (5) step(1'b0, 32'h0, 1'b0, 100);
        tests_run++;
        if (instr_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_prefill got v=%b want 1", instr_valid);
        end
        apply_reset();
        repeat (3) step(1'b0, 32'h0, 1'b0, 100);
        tests_run++;
        if (iss_q.size() == 0 || iss_q[0] !== RST_PC) begin
            tests_failed++;
            $display("FAIL mid_restart got n=%0d want first req %h", iss_q.size(), RST_PC);
        end
    endtask

    task automatic test_random();
        int total;
        total = 0;
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                total += acc_pc.size();
                apply_reset();
            end
            step($urandom_range(99) < 4, $urandom, 1'($urandom_range(1)), 60);
        end
        total += acc_pc.size();
        tests_run++;
        if (total < 200) begin
            tests_failed++;
            $display("FAIL random_progress got %0d accepted want >=200", total);
        end
    endtask

    initial begin
        rst           = 1'b0;
        imem_rvalid   = 1'b0;
        imem_rdata    = 32'h0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        instr_ready   = 1'b0;
        exp_issue     = RST_PC;
        test_reset();
        test_sequential();
        test_stall();
        test_flush();
        test_rsp_branch();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
